// File: rtl/cayde_fetch.sv
// cayde_fetch: instruction fetch stage; PC, single-outstanding imem port, prefetch FIFO to the decoder.
// Optional build macro CAYDE_FETCH_MISALIGN_EN adds fetch_misalign_o and a HALT state for misaligned redirects.
//
// state | meaning
// IDLE  | just out of reset, loads BOOT_ADDR
// REQ   | request (when FIFO has room), waiting for gnt
// WAIT  | one request outstanding, waiting for rvalid
// HALT  | misaligned redirect seen, no fetching (CAYDE_FETCH_MISALIGN_EN only)
module cayde_fetch #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
`ifdef CAYDE_FETCH_MISALIGN_EN
  output logic        fetch_misalign_o,
`endif
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

`ifdef CAYDE_FETCH_MISALIGN_EN
  typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t        state_q, state_n;
  logic [31:0]   fetch_pc_q, fetch_pc_n;
  logic [31:0]   req_pc_q, req_pc_n;
  logic          req_q, req_n;
  logic          out_q, out_n;
  logic          disc_q, disc_n;
  logic [CW-1:0] cnt_q, cnt_n;
  entry_t        fifo_q [FIFO_DEPTH];
  entry_t        fifo_n [FIFO_DEPTH];

  logic          gnt_fire, rsp_fire, push, pop;
  logic [31:0]   redir_pc;

`ifdef CAYDE_FETCH_MISALIGN_EN
  logic          misalign_q, misalign_n;
  logic          redir_bad;
  assign redir_bad        = redirect_pc_i[1] | redirect_pc_i[0];
  assign fetch_misalign_o = misalign_q;
`else
  logic          unused_redir_lsb;
  assign unused_redir_lsb = ^redirect_pc_i[1:0];
`endif

  assign redir_pc      = {redirect_pc_i[31:2], 2'b00};
  assign gnt_fire      = req_q & imem_gnt_i;
  // rvalid only means something while a request is actually outstanding
  assign rsp_fire      = out_q & imem_rvalid_i;
  assign push          = rsp_fire & ~disc_q & ~redirect_i;
  assign pop           = instr_valid_o & instr_ready_i;

  assign imem_req_o    = req_q;
  assign imem_addr_o   = fetch_pc_q;
  assign instr_valid_o = (cnt_q != '0);
  assign instr_o       = fifo_q[0].instr;
  assign instr_pc_o    = fifo_q[0].pc;

  // Shift-register FIFO: entry 0 is the head; it is left untouched when the
  // FIFO empties or flushes so the decoder-facing outputs hold their last value.
  always_comb begin
    fifo_n = fifo_q;
    cnt_n  = cnt_q;
    if (pop && !redirect_i) begin
      for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
        if (i + 1 < int'(cnt_q)) fifo_n[i] = fifo_q[i+1];
      end
      cnt_n = cnt_q - ONE_C;
    end
    if (push) begin
      fifo_n[cnt_n[IW-1:0]] = '{pc: req_pc_q, instr: imem_rdata_i};
      cnt_n = cnt_n + ONE_C;
    end
    if (redirect_i) cnt_n = '0;
  end

  always_comb begin
    state_n    = state_q;
    fetch_pc_n = fetch_pc_q;
    req_pc_n   = req_pc_q;
    out_n      = out_q;
    disc_n     = disc_q;
`ifdef CAYDE_FETCH_MISALIGN_EN
    misalign_n = misalign_q;
`endif
    if (rsp_fire) begin
      out_n  = 1'b0;
      disc_n = 1'b0;
    end
    if (gnt_fire) begin
      out_n      = 1'b1;
      req_pc_n   = fetch_pc_q;
      fetch_pc_n = fetch_pc_q + 32'd4;
    end
    case (state_q)
      IDLE: begin
        state_n    = REQ;
        fetch_pc_n = BOOT_ADDR;
      end
      REQ:  if (gnt_fire) state_n = WAIT;
      WAIT: if (rsp_fire) state_n = REQ;
`ifdef CAYDE_FETCH_MISALIGN_EN
      HALT: state_n = HALT;
`endif
      default: state_n = IDLE;
    endcase
    // A response still in flight after a redirect belongs to the old stream
    if (redirect_i) begin
      disc_n = out_n;
`ifdef CAYDE_FETCH_MISALIGN_EN
      if (redir_bad) begin
        state_n    = HALT;
        misalign_n = 1'b1;
      end else begin
        fetch_pc_n = redir_pc;
        state_n    = out_n ? WAIT : REQ;
        misalign_n = 1'b0;
      end
`else
      fetch_pc_n = redir_pc;
      state_n    = out_n ? WAIT : REQ;
`endif
    end
    // out_n is always 0 when state_n is REQ, so cnt_n alone is the room check
    req_n = (state_n == REQ) && (state_q != IDLE) && !redirect_i && (cnt_n < DEPTH_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= BOOT_ADDR;
      req_pc_q   <= BOOT_ADDR;
      req_q      <= 1'b0;
      out_q      <= 1'b0;
      disc_q     <= 1'b0;
`ifdef CAYDE_FETCH_MISALIGN_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_n;
      fetch_pc_q <= fetch_pc_n;
      req_pc_q   <= req_pc_n;
      req_q      <= req_n;
      out_q      <= out_n;
      disc_q     <= disc_n;
`ifdef CAYDE_FETCH_MISALIGN_EN
      misalign_q <= misalign_n;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      cnt_q  <= cnt_n;
      fifo_q <= fifo_n;
    end
  end

endmodule

// File: tb/tb_cayde_fetch.sv
// tb_cayde_fetch: directed bench for cayde_fetch with a budgeted imem responder and an instruction scoreboard.
// Honours CAYDE_FETCH_MISALIGN_EN to exercise the misaligned-redirect trap.
module tb_cayde_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
`ifdef CAYDE_FETCH_MISALIGN_EN
  logic        fetch_misalign_o;
`endif

  cayde_fetch dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
`ifdef CAYDE_FETCH_MISALIGN_EN
    .fetch_misalign_o (fetch_misalign_o),
`endif
    .instr_valid_o    (instr_valid_o),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o),
    .instr_ready_i    (instr_ready_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  int          budget  = 0;
  int          gnt_lat = 0;
  int          rsp_lat = 0;
  int          grants  = 0;
  int          req_seen = 0;
  int          pend_wait = 0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0010_0093 : (32'hC000_0000 | a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_word(input logic [31:0] pc);
    exp_q.push_back('{instr: mem_word(pc), pc: pc});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Memory model: grants while budget remains (after gnt_lat waiting cycles),
  // answers rsp_lat cycles after the cycle following the grant.
  initial begin
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = '0;
    forever begin
      @(posedge clk);
      #2;
      imem_gnt_i    = 1'b0;
      imem_rvalid_i = 1'b0;
      if (pend) begin
        if (pend_wait == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = mem_word(pend_addr);
          pend = 1'b0;
        end else begin
          pend_wait--;
        end
      end
      if (imem_req_o && budget > 0) begin
        if (req_seen >= gnt_lat) begin
          imem_gnt_i = 1'b1;
          pend       = 1'b1;
          pend_addr  = imem_addr_o;
          pend_wait  = rsp_lat;
          req_seen   = 0;
          budget--;
          grants++;
        end else begin
          req_seen++;
        end
      end else begin
        req_seen = 0;
      end
    end
  end

  // Scoreboard monitor: every accepted instruction must match the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid_o && instr_ready_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_instr_pc", instr_pc_o, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_instr", instr_o, e.instr);
          chk("sb_pc", instr_pc_o, e.pc);
        end
      end
    end
  end

  initial begin
    rst           = 1'b1;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;
    instr_ready_i = 1'b0;
    budget        = 4;
    expect_word(32'h0);
    expect_word(32'h4);
    expect_word(32'h8);
    expect_word(32'hC);
    cyc(3);
    chk("rst_req", {31'b0, imem_req_o}, 32'd0);
    chk("rst_addr", imem_addr_o, 32'h0);
    chk("rst_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", instr_pc_o, 32'h0);
    rst = 1'b0;

    // first request on the second edge after release, then stall with ready low
    cyc(1);
    chk("first_edge_req", {31'b0, imem_req_o}, 32'd0);
    cyc(1);
    chk("second_edge_req", {31'b0, imem_req_o}, 32'd1);
    chk("first_addr", imem_addr_o, 32'h0);
    cyc(1);
    chk("second_addr", imem_addr_o, 32'h4);
    chk("wait_req_low", {31'b0, imem_req_o}, 32'd0);
    cyc(8);
    chk("stall_grants", grants, 32'd2);
    chk("stall_req_low", {31'b0, imem_req_o}, 32'd0);
    chk("stall_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("stall_head_instr", instr_o, 32'h0010_0093);
    chk("stall_head_pc", instr_pc_o, 32'h0);
    instr_ready_i = 1'b1;
    cyc(14);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("drain_req", {31'b0, imem_req_o}, 32'd1);
    chk("drain_addr", imem_addr_o, 32'h10);

    // grant held off for 3 cycles: request must stay put
    gnt_lat = 3;
    budget  = 1;
    expect_word(32'h10);
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      chk("gnt_wait_req", {31'b0, imem_req_o}, 32'd1);
      chk("gnt_wait_addr", imem_addr_o, 32'h10);
    end
    cyc(6);
    gnt_lat = 0;
    chk("gnt_wait_empty", 32'(exp_q.size()), 32'd0);

    // redirect while the request to 0x14 is outstanding
    chk("pre_redir_req", {31'b0, imem_req_o}, 32'd1);
    chk("pre_redir_addr", imem_addr_o, 32'h14);
    rsp_lat = 3;
    budget  = 1;
    cyc(1);
    chk("outstanding_req", {31'b0, imem_req_o}, 32'd0);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    cyc(1);
    redirect_i = 1'b0;
    chk("redir_addr", imem_addr_o, 32'h100);
    chk("redir_req", {31'b0, imem_req_o}, 32'd0);
    chk("redir_valid", {31'b0, instr_valid_o}, 32'd0);
    cyc(3);
    chk("redir_new_req", {31'b0, imem_req_o}, 32'd1);
    chk("redir_new_addr", imem_addr_o, 32'h100);
    chk("redir_dropped", {31'b0, instr_valid_o}, 32'd0);
    rsp_lat = 0;
    budget  = 1;
    expect_word(32'h100);
    cyc(5);
    chk("redir_deliver_empty", 32'(exp_q.size()), 32'd0);

    // redirect coincident with a grant and with a pop
    instr_ready_i = 1'b0;
    budget        = 1;
    expect_word(32'h104);
    cyc(4);
    chk("co_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("co_head_pc", instr_pc_o, 32'h104);
    chk("co_req", {31'b0, imem_req_o}, 32'd1);
    chk("co_addr", imem_addr_o, 32'h108);
    instr_ready_i = 1'b1;
    budget        = 1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    cyc(1);
    redirect_i = 1'b0;
    chk("co_flush_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("co_flush_req", {31'b0, imem_req_o}, 32'd0);
    chk("co_flush_addr", imem_addr_o, 32'h200);
    cyc(1);
    chk("co_resume_req", {31'b0, imem_req_o}, 32'd1);
    chk("co_resume_addr", imem_addr_o, 32'h200);
    chk("co_no_dup", {31'b0, instr_valid_o}, 32'd0);

    // full FIFO popped in the redirect cycle
    instr_ready_i = 1'b0;
    budget        = 2;
    expect_word(32'h200);
    cyc(6);
    chk("full_valid", {31'b0, instr_valid_o}, 32'd1);
    chk("full_head_pc", instr_pc_o, 32'h200);
    chk("full_req_low", {31'b0, imem_req_o}, 32'd0);
    instr_ready_i = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h300;
    cyc(1);
    redirect_i = 1'b0;
    chk("full_flush_valid", {31'b0, instr_valid_o}, 32'd0);
    chk("full_flush_req", {31'b0, imem_req_o}, 32'd0);
    chk("full_flush_addr", imem_addr_o, 32'h300);
    cyc(1);
    chk("full_resume_req", {31'b0, imem_req_o}, 32'd1);
    chk("full_resume_addr", imem_addr_o, 32'h300);
    cyc(3);
    chk("full_no_dup", {31'b0, instr_valid_o}, 32'd0);
    budget = 1;
    expect_word(32'h300);
    cyc(5);
    chk("full_deliver_empty", 32'(exp_q.size()), 32'd0);

`ifdef CAYDE_FETCH_MISALIGN_EN
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h102;
    cyc(1);
    redirect_i = 1'b0;
    chk("mis_flag_set", {31'b0, fetch_misalign_o}, 32'd1);
    chk("mis_req_low", {31'b0, imem_req_o}, 32'd0);
    cyc(3);
    chk("mis_halt_req", {31'b0, imem_req_o}, 32'd0);
    chk("mis_halt_flag", {31'b0, fetch_misalign_o}, 32'd1);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    cyc(1);
    redirect_i = 1'b0;
    chk("mis_flag_clr", {31'b0, fetch_misalign_o}, 32'd0);
    chk("mis_clr_addr", imem_addr_o, 32'h200);
    cyc(1);
    chk("mis_resume_req", {31'b0, imem_req_o}, 32'd1);
    chk("mis_resume_addr", imem_addr_o, 32'h200);
    budget = 1;
    expect_word(32'h200);
    cyc(5);
`else
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h502;
    cyc(1);
    redirect_i = 1'b0;
    chk("lsb_forced_addr", imem_addr_o, 32'h500);
    chk("lsb_req_low", {31'b0, imem_req_o}, 32'd0);
    cyc(1);
    chk("lsb_resume_req", {31'b0, imem_req_o}, 32'd1);
    chk("lsb_resume_addr", imem_addr_o, 32'h500);
    budget = 1;
    expect_word(32'h500);
    cyc(5);
`endif
    chk("final_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
